// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port RAM arbiter.
// Port ids double as the round-robin pointer and the read-return tag.
package mem_arb_pkg;

  localparam int AW_DEF       = 12;
  localparam int DW_DEF       = 16;
  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 2;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  typedef struct packed {
    logic  vld;
    port_e port;
  } rd_tag_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of both requester ports plus the RAM side of the arbiter.
// slave is the arbiter's view; master is the requesters-plus-RAM view.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic          a_req;
  logic          a_we;
  logic          a_lock;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_gnt;
  logic          a_rvalid;
  logic [DW-1:0] a_rdata;

  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_gnt;
  logic          b_rvalid;
  logic [DW-1:0] b_rdata;

  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic          m_wren;
  logic [DW-1:0] m_q;

  modport slave (
    input  a_req, a_we, a_lock, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata,
    output m_addr, m_data, m_wren,
    input  m_q
  );

  modport master (
    output a_req, a_we, a_lock, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  m_addr, m_data, m_wren,
    output m_q
  );

endinterface

// File: rtl/rd_tag_pipe.sv
// Shift register of {valid, port} tags, DEPTH stages, aligned with RAM read latency.
// No backpressure: one tag enters every cycle; reset discards all in-flight tags.
module rd_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clock,
  input  logic    reset,
  input  rd_tag_t in_tag,
  output rd_tag_t out_tag
);

  rd_tag_t stg_q [DEPTH];
  rd_tag_t stg_d [DEPTH];

  always_comb begin
    stg_d[0] = in_tag;
    for (int i = 1; i < DEPTH; i++) begin
      stg_d[i] = stg_q[i-1];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stg_q[i] <= '0;
      end
    end else begin
      stg_q <= stg_d;
    end
  end

  assign out_tag = stg_q[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin (with A lock) arbiter sharing one synchronous RAM between ports A and B.
// Grant and RAM controls are combinational; read data returns READ_LAT cycles after the grant edge.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int READ_LAT = 1
) (
  input logic          clock,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam int LAT = (READ_LAT < READ_LAT_MIN) ? READ_LAT_MIN :
                       (READ_LAT > READ_LAT_MAX) ? READ_LAT_MAX : READ_LAT;

  port_e         ptr_q, ptr_d;
  logic          a_gnt, b_gnt;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic          m_wren;
  rd_tag_t       tag_in, tag_out;
  logic          a_rvalid, b_rvalid;
  logic [DW-1:0] a_rdata_q, a_rdata_d;
  logic [DW-1:0] b_rdata_q, b_rdata_d;

  always_comb begin
    a_gnt  = bus.a_req & (~bus.b_req | (ptr_q == PORT_A));
    b_gnt  = bus.b_req & ~a_gnt;
    m_addr = '0;
    m_data = '0;
    m_wren = 1'b0;
    ptr_d  = ptr_q;
    tag_in = '0;
    if (a_gnt) begin
      m_addr      = bus.a_addr;
      m_data      = bus.a_wdata;
      m_wren      = bus.a_we;
      // A locked transfer keeps priority for A's next contested request
      ptr_d       = bus.a_lock ? PORT_A : PORT_B;
      tag_in.vld  = ~bus.a_we;
      tag_in.port = PORT_A;
    end else if (b_gnt) begin
      m_addr      = bus.b_addr;
      m_data      = bus.b_wdata;
      m_wren      = bus.b_we;
      ptr_d       = PORT_A;
      tag_in.vld  = ~bus.b_we;
      tag_in.port = PORT_B;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q <= PORT_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  rd_tag_pipe #(
    .DEPTH (LAT)
  ) u_rd_tag_pipe (
    .clock   (clock),
    .reset   (reset),
    .in_tag  (tag_in),
    .out_tag (tag_out)
  );

  // Returned data passes straight through on the valid cycle and is held afterwards
  always_comb begin
    a_rvalid  = tag_out.vld & (tag_out.port == PORT_A);
    b_rvalid  = tag_out.vld & (tag_out.port == PORT_B);
    a_rdata_d = a_rvalid ? bus.m_q : a_rdata_q;
    b_rdata_d = b_rvalid ? bus.m_q : b_rdata_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign bus.a_gnt    = a_gnt;
  assign bus.b_gnt    = b_gnt;
  assign bus.m_addr   = m_addr;
  assign bus.m_data   = m_data;
  assign bus.m_wren   = m_wren;
  assign bus.a_rvalid = a_rvalid;
  assign bus.b_rvalid = b_rvalid;
  assign bus.a_rdata  = a_rdata_d;
  assign bus.b_rdata  = b_rdata_d;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: two arbiters (READ_LAT=1 and 2) share the same requester stimulus,
// each with its own RAM model of matching latency.
module tb_mem_arbiter;

  logic clock;
  logic reset;

  logic        a_req, a_we, a_lock;
  logic [11:0] a_addr;
  logic [15:0] a_wdata;
  logic        b_req, b_we;
  logic [11:0] b_addr;
  logic [15:0] b_wdata;

  int passed = 0;
  int total  = 0;

  mem_arbiter_if #(.AW(12), .DW(16)) bus1 ();
  mem_arbiter_if #(.AW(12), .DW(16)) bus2 ();

  mem_arbiter #(.AW(12), .DW(16), .READ_LAT(1)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  mem_arbiter #(.AW(12), .DW(16), .READ_LAT(2)) dut2 (
    .clock (clock),
    .reset (reset),
    .bus   (bus2)
  );

  assign bus1.a_req   = a_req;
  assign bus1.a_we    = a_we;
  assign bus1.a_lock  = a_lock;
  assign bus1.a_addr  = a_addr;
  assign bus1.a_wdata = a_wdata;
  assign bus1.b_req   = b_req;
  assign bus1.b_we    = b_we;
  assign bus1.b_addr  = b_addr;
  assign bus1.b_wdata = b_wdata;
  assign bus2.a_req   = a_req;
  assign bus2.a_we    = a_we;
  assign bus2.a_lock  = a_lock;
  assign bus2.a_addr  = a_addr;
  assign bus2.a_wdata = a_wdata;
  assign bus2.b_req   = b_req;
  assign bus2.b_we    = b_we;
  assign bus2.b_addr  = b_addr;
  assign bus2.b_wdata = b_wdata;

  logic [15:0] mem1 [0:4095];
  logic [15:0] mem2 [0:4095];
  logic [15:0] q1, q2a, q2;

  always @(posedge clock) begin
    if (bus1.m_wren) mem1[bus1.m_addr] <= bus1.m_data;
    q1 <= mem1[bus1.m_addr];
  end

  always @(posedge clock) begin
    if (bus2.m_wren) mem2[bus2.m_addr] <= bus2.m_data;
    q2a <= mem2[bus2.m_addr];
    q2  <= q2a;
  end

  assign bus1.m_q = q1;
  assign bus2.m_q = q2;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Return check for both instances: valid flags per port, data checked when valid
  task automatic rets(input string tag,
                      input logic e1a, input logic e1b, input logic [15:0] d1,
                      input logic e2a, input logic e2b, input logic [15:0] d2);
    chk({tag, " lat1 a_rvalid"}, bus1.a_rvalid, e1a);
    chk({tag, " lat1 b_rvalid"}, bus1.b_rvalid, e1b);
    chk({tag, " lat2 a_rvalid"}, bus2.a_rvalid, e2a);
    chk({tag, " lat2 b_rvalid"}, bus2.b_rvalid, e2b);
    if (e1a) chk({tag, " lat1 a_rdata"}, bus1.a_rdata, d1);
    if (e1b) chk({tag, " lat1 b_rdata"}, bus1.b_rdata, d1);
    if (e2a) chk({tag, " lat2 a_rdata"}, bus2.a_rdata, d2);
    if (e2b) chk({tag, " lat2 b_rdata"}, bus2.b_rdata, d2);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  logic [11:0] ca_addr [4] = '{12'h100, 12'h101, 12'h102, 12'h103};
  logic [15:0] ca_data [4] = '{16'hA000, 16'hA001, 16'hA002, 16'hA003};
  logic [11:0] cb_addr [4] = '{12'h010, 12'h011, 12'h012, 12'h013};
  logic [15:0] cb_data [4] = '{16'hBEEF, 16'hB001, 16'hB002, 16'hB003};
  logic [11:0] pa_addr [5] = '{12'h102, 12'h101, 12'h100, 12'h7FF, 12'h000};
  logic [11:0] pb_addr [4] = '{12'h012, 12'h010, 12'h011, 12'h7FF};
  logic [15:0] ret_dat [8] = '{16'hA002, 16'hB002, 16'hA001, 16'hBEEF,
                               16'hA000, 16'hB001, 16'h1234, 16'h1234};

  int          ai, bi;
  logic        e1a, e1b, e2a, e2b;
  logic [15:0] d1, d2;

  initial begin
    reset = 1'b1;
    a_req = 0; a_we = 0; a_lock = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;

    #2;
    chk("rst a_gnt", bus1.a_gnt, 1'b0);
    chk("rst b_gnt", bus1.b_gnt, 1'b0);
    chk("rst m_wren", bus1.m_wren, 1'b0);
    chk("rst m_addr", bus1.m_addr, 12'h000);
    chk("rst m_data", bus1.m_data, 16'h0000);
    chk("rst lat1 a_rdata", bus1.a_rdata, 16'h0000);
    chk("rst lat2 b_rdata", bus2.b_rdata, 16'h0000);
    rets("rst", 0, 0, 16'h0, 0, 0, 16'h0);

    // Pointer is A while in reset
    a_req = 1; b_req = 1;
    #1;
    chk("rst ptr a_gnt", bus1.a_gnt, 1'b1);
    chk("rst ptr b_gnt", bus1.b_gnt, 1'b0);
    a_req = 0; b_req = 0;
    cyc();
    reset = 1'b0;

    // Contention with writes; these also preload the RAM
    for (int k = 0; k < 6; k++) begin
      ai = (k + 1) / 2;
      bi = k / 2;
      a_req = 1; a_we = 1; a_addr = ca_addr[ai]; a_wdata = ca_data[ai];
      b_req = 1; b_we = 1; b_addr = cb_addr[bi]; b_wdata = cb_data[bi];
      #1;
      chk("cont a_gnt", bus1.a_gnt, (k % 2) == 0);
      chk("cont b_gnt", bus1.b_gnt, (k % 2) == 1);
      chk("cont lat2 a_gnt", bus2.a_gnt, (k % 2) == 0);
      chk("cont m_wren", bus1.m_wren, 1'b1);
      chk("cont m_addr", bus1.m_addr, ((k % 2) == 0) ? ca_addr[ai] : cb_addr[bi]);
      chk("cont m_data", bus1.m_data, ((k % 2) == 0) ? ca_data[ai] : cb_data[bi]);
      rets("cont", 0, 0, 16'h0, 0, 0, 16'h0);
      cyc();
    end

    a_req = 0; b_req = 0; a_we = 0; b_we = 0;
    #1;
    chk("idle a_gnt", bus1.a_gnt, 1'b0);
    chk("idle b_gnt", bus1.b_gnt, 1'b0);
    chk("idle m_wren", bus1.m_wren, 1'b0);
    chk("idle m_addr", bus1.m_addr, 12'h000);
    chk("idle m_data", bus1.m_data, 16'h0000);
    cyc();

    // Solo read from B
    b_req = 1; b_we = 0; b_addr = 12'h010;
    #1;
    chk("solo b_gnt", bus1.b_gnt, 1'b1);
    chk("solo a_gnt", bus1.a_gnt, 1'b0);
    chk("solo m_addr", bus1.m_addr, 12'h010);
    chk("solo m_wren", bus1.m_wren, 1'b0);
    rets("solo c0", 0, 0, 16'h0, 0, 0, 16'h0);
    cyc();
    b_req = 0;
    #1;
    rets("solo c1", 0, 1, 16'hBEEF, 0, 0, 16'h0);
    cyc();
    rets("solo c2", 0, 0, 16'h0, 0, 1, 16'hBEEF);
    chk("solo lat1 b_rdata hold", bus1.b_rdata, 16'hBEEF);
    cyc();

    // Lock: A keeps winning for three locked requests against B
    a_req = 1; a_we = 0; a_lock = 1; a_addr = 12'h100;
    b_req = 1; b_we = 0; b_addr = 12'h011;
    #1;
    chk("lock0 a_gnt", bus1.a_gnt, 1'b1);
    chk("lock0 b_gnt", bus1.b_gnt, 1'b0);
    rets("lock0", 0, 0, 16'h0, 0, 0, 16'h0);
    cyc();
    a_addr = 12'h101;
    #1;
    chk("lock1 a_gnt", bus1.a_gnt, 1'b1);
    chk("lock1 b_gnt", bus1.b_gnt, 1'b0);
    rets("lock1", 1, 0, 16'hA000, 0, 0, 16'h0);
    cyc();
    a_addr = 12'h102;
    #1;
    chk("lock2 a_gnt", bus1.a_gnt, 1'b1);
    chk("lock2 b_gnt", bus1.b_gnt, 1'b0);
    rets("lock2", 1, 0, 16'hA001, 1, 0, 16'hA000);
    cyc();
    a_req = 0; a_lock = 0;
    #1;
    chk("lock3 b_gnt", bus1.b_gnt, 1'b1);
    chk("lock3 a_gnt", bus1.a_gnt, 1'b0);
    rets("lock3", 1, 0, 16'hA002, 1, 0, 16'hA001);
    cyc();
    b_req = 0;
    #1;
    rets("lock4", 0, 1, 16'hB001, 1, 0, 16'hA002);
    cyc();
    rets("lock5", 0, 0, 16'h0, 0, 1, 16'hB001);
    cyc();

    // Write by A, read back by B the next cycle
    a_req = 1; a_we = 1; a_addr = 12'h7FF; a_wdata = 16'h1234;
    #1;
    chk("wr a_gnt", bus1.a_gnt, 1'b1);
    chk("wr m_wren", bus1.m_wren, 1'b1);
    chk("wr m_addr", bus1.m_addr, 12'h7FF);
    chk("wr m_data", bus1.m_data, 16'h1234);
    cyc();
    a_req = 0; a_we = 0;
    b_req = 1; b_we = 0; b_addr = 12'h7FF;
    #1;
    chk("rd b_gnt", bus1.b_gnt, 1'b1);
    chk("rd m_wren", bus1.m_wren, 1'b0);
    rets("rd c0", 0, 0, 16'h0, 0, 0, 16'h0);
    cyc();
    b_req = 0;
    #1;
    chk("rd c1 m_wren", bus1.m_wren, 1'b0);
    rets("rd c1", 0, 1, 16'h1234, 0, 0, 16'h0);
    cyc();
    rets("rd c2", 0, 0, 16'h0, 0, 1, 16'h1234);
    cyc();

    // Alternating reads with both ports requesting every cycle
    for (int k = 0; k < 10; k++) begin
      if (k < 8) begin
        ai = (k + 1) / 2;
        bi = k / 2;
        a_req = 1; a_we = 0; a_addr = pa_addr[ai];
        b_req = 1; b_we = 0; b_addr = pb_addr[bi];
      end else begin
        a_req = 0; b_req = 0;
      end
      #1;
      if (k < 8) begin
        chk("pipe a_gnt", bus1.a_gnt, (k % 2) == 0);
        chk("pipe b_gnt", bus1.b_gnt, (k % 2) == 1);
      end
      e1a = 0; e1b = 0; d1 = '0;
      e2a = 0; e2b = 0; d2 = '0;
      if (k >= 1 && k <= 8) begin
        e1a = ((k - 1) % 2) == 0;
        e1b = ((k - 1) % 2) == 1;
        d1  = ret_dat[k-1];
      end
      if (k >= 2) begin
        e2a = ((k - 2) % 2) == 0;
        e2b = ((k - 2) % 2) == 1;
        d2  = ret_dat[k-2];
      end
      rets("pipe", e1a, e1b, d1, e2a, e2b, d2);
      cyc();
    end

    // Reset one cycle after a granted A read discards it and restores pointer A
    a_req = 1; a_we = 0; a_addr = 12'h100;
    #1;
    chk("rstrd a_gnt", bus2.a_gnt, 1'b1);
    rets("rstrd c0", 0, 0, 16'h0, 0, 0, 16'h0);
    cyc();
    a_req = 0;
    reset = 1'b1;
    #1;
    rets("rstrd c1", 0, 0, 16'h0, 0, 0, 16'h0);
    chk("rstrd lat2 a_rdata", bus2.a_rdata, 16'h0000);
    cyc();
    reset = 1'b0;
    #1;
    rets("rstrd c2", 0, 0, 16'h0, 0, 0, 16'h0);
    cyc();
    a_req = 1; b_req = 1; a_we = 0; b_we = 0;
    #1;
    chk("rstrd ptr lat2 a_gnt", bus2.a_gnt, 1'b1);
    chk("rstrd ptr lat2 b_gnt", bus2.b_gnt, 1'b0);
    chk("rstrd ptr lat1 a_gnt", bus1.a_gnt, 1'b1);
    rets("rstrd c3", 0, 0, 16'h0, 0, 0, 16'h0);
    cyc();
    a_req = 0; b_req = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, 12, RAM address width (4096 words).
REQ-002 Parameter DW, 16, RAM data width.
REQ-003 Parameter READ_LAT, 1, cycles from granted read address to valid m_q; legal values are 1 and 2.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset, with ports named clock and reset.
REQ-005 Ports:
- clock, in, 1: rising-edge clock.
- reset, in, 1: async active-high reset.
- a_req, in, 1: processor port request.
- a_we, in, 1: processor write (1) or read (0).
- a_lock, in, 1: processor keeps priority for its next request (read-modify-write).
- a_addr, in, AW: processor address.
- a_wdata, in, DW: processor write data.
- a_gnt, out, 1: processor request accepted this cycle.
- a_rvalid, out, 1: processor read data valid.
- a_rdata, out, DW: processor read data.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same meaning, for the auxiliary port (loader/display); port B has no lock.
- m_addr, out, AW: RAM address.
- m_data, out, DW: RAM write data.
- m_wren, out, 1: RAM write enable.
- m_q, in, DW: RAM read data.

Function
REQ-006 The block SHALL share one single-port synchronous RAM between ports A and B; at most one gnt is high per cycle.
REQ-007 A transfer occurs on the rising edge where req and gnt are both high; the requester holds req, we, addr and wdata stable until then.
REQ-008 gnt is combinational from the req inputs and the registered priority pointer; m_addr, m_data and m_wren are muxed combinationally from the granted port.
REQ-009 With no grant: m_wren=0, m_addr=0, m_data=0.
REQ-010 When only one port requests, that port is granted regardless of the pointer.
REQ-011 When both ports request, the port named by the pointer is granted.
REQ-012 After each grant, the pointer moves to the other port (round-robin).
REQ-013 Exception to REQ-012: if A is granted with a_lock=1, the pointer stays at A, so A wins the next contested cycle.
REQ-014 Lock SHALL NOT block B while A is idle (REQ-010 applies).
REQ-015 A granted read SHALL produce exactly one rvalid pulse on the owning port, READ_LAT cycles after the grant edge, with rdata=m_q.
- rvalid is 0 on the other port in that cycle.
- rdata on a port not valid this cycle holds its last value.
REQ-016 Read ownership SHALL be tracked by a READ_LAT-deep tag pipeline of {valid, port}; back-to-back reads from alternating ports return in grant order with no bubbles.
REQ-017 Writes SHALL produce no rvalid.
REQ-018 The arbiter adds no read-after-write bypass: a read granted the cycle after a write to the same address returns whatever the RAM returns (new data for this RAM).
REQ-019 Throughput SHALL be one transfer per cycle, sustained, with no idle cycle between grants.

Reset
REQ-020 During reset and after its release: pointer = A; tag pipeline cleared; a_rvalid = b_rvalid = 0; a_rdata = b_rdata = 0; gnt and m_wren follow REQ-008/009 using the reset pointer.
REQ-021 An assertion of reset while reads are in flight SHALL discard them: no rvalid appears after reset deasserts for reads granted before reset.

Structure
REQ-022 Package mem_arb_pkg SHALL hold the AW/DW defaults, the READ_LAT bounds and the port-id enum (PORT_A, PORT_B).
REQ-023 One sub-module, rd_tag_pipe (READ_LAT-stage shift register of {valid, port id}), SHALL be instantiated.
- All other logic stays in mem_arbiter.
- Target size is 120-400 lines total.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Solo read: B reads addr 0x010 holding 0xBEEF, A idle. Required: b_gnt in the same cycle; b_rvalid=1 with b_rdata=0xBEEF READ_LAT cycles later; a_rvalid stays 0.
- Contention: both ports request continuously for 6 cycles from reset. Required: grants alternate A,B,A,B,A,B.
- Lock: A requests with a_lock=1 for 3 cycles while B also requests. Required: A is granted 3 times; B is granted on the first cycle after a_lock drops.
- Write then read: A writes 0x1234 to 0x7FF, then B reads 0x7FF. Required: b_rdata=0x1234; m_wren=1 only in the write cycle.
- Reset mid-read: reset asserted one cycle after a granted A read, READ_LAT=2. Required: no a_rvalid ever appears; pointer=A after reset.
- Pipelined returns: alternating A/B reads for 8 cycles with READ_LAT=1 and =2. Required: each read returns on the correct port, in order, with no lost or duplicated rvalid.
